minmax_reduce_uint: RTL and testbench
=====================================

MINMAX_REDUCE_UINT -- requirements
Module: minmax_reduce_uint

Interface
REQ-001 Parameter WIDTH, default 64: element width in bits, unsigned.
REQ-002 Parameter IDX_WIDTH, default 16: width of the index and count outputs.
REQ-003 Parameter IMPL_TYPE, default 0: selects the greater-than comparator implementation; it SHALL NOT change cycle behaviour.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 abort  input  1  synchronous discard of the partial burst.
REQ-007 mode  input  1  0 = min, 1 = max; sampled on the first beat of a burst only.
REQ-008 in_valid  input  1  element valid.
REQ-009 in_ready  output  1  element accepted when in_valid and in_ready are both high.
REQ-010 in_data  input  WIDTH  element value.
REQ-011 in_last  input  1  marks the final element of the burst.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  result consumed when out_valid and out_ready are both high.
REQ-014 out_data  output  WIDTH  min or max value of the burst.
REQ-015 out_index  output  IDX_WIDTH  zero-based position of the winning element.
REQ-016 out_count  output  IDX_WIDTH  number of elements in the burst.
REQ-017 out_ovf  output  1  the burst exceeded 2^IDX_WIDTH-1 elements.

Function
REQ-018 FSM states SHALL be IDLE, ACCUM and DONE; state is IDLE after reset.
REQ-019 in_ready SHALL equal (state != DONE) AND NOT abort.
REQ-020 First beat accepted in IDLE: acc = in_data, idx = 0, count = 1, latch mode; go to DONE if in_last, otherwise to ACCUM.
REQ-021 Accepted beat in ACCUM, position p = count: in min mode, replace acc/idx when in_data < acc; in max mode, replace when in_data > acc; then count = count + 1.
REQ-022 Ties SHALL NOT replace, so the earliest winning position is reported.
REQ-023 A beat accepted with in_last in ACCUM SHALL be compared, and the FSM SHALL go to DONE in the same edge.
REQ-024 out_valid SHALL be high in DONE, first asserted the cycle after the last beat is accepted.
REQ-025 No combinational path SHALL exist from in_* to out_*.
REQ-026 While in DONE, out_data, out_index, out_count and out_ovf SHALL stay stable until out_ready.
REQ-027 DONE with out_ready high SHALL go to IDLE on that edge.
REQ-028 Throughput is one element per cycle within a burst; consecutive bursts have at least one bubble cycle.
REQ-029 Count/index saturation: count and position saturate at 2^IDX_WIDTH-1.
REQ-030 When saturated, out_ovf is set (sticky per burst), comparison continues, and a replacement records index 2^IDX_WIDTH-1.
REQ-031 abort high in ACCUM or IDLE SHALL go to IDLE, discard acc, idx and count, and accept no beat.
REQ-032 abort high in DONE SHALL be ignored; the result is still delivered.
REQ-033 A change on mode mid-burst SHALL have no effect.
REQ-034 The comparison SHALL be unsigned over the full WIDTH bits.

Reset
REQ-035 rst_n low SHALL immediately force state to IDLE and set out_valid, out_data, out_index, out_count and out_ovf to 0.
REQ-036 in_ready SHALL be 1 after reset once abort is low.
REQ-037 Reset in any state, including mid-burst in ACCUM, SHALL discard the partial result.
REQ-038 The first burst after reset release SHALL behave as if no prior burst occurred.

Verification (WIDTH=8, IDX_WIDTH=4 unless stated)
REQ-039 mode=0, burst 5,3,9,3(last) -> out_data=3, out_index=1, out_count=4, out_ovf=0, out_valid one cycle after the last beat.
REQ-040 mode=1, burst 7,200,200,1(last), with mode toggled to 0 on beat 2 -> out_data=200, out_index=1, out_count=4.
REQ-041 WIDTH=64, mode=0, single beat 0xFFFF_FFFF_FFFF_FFFF with last -> out_data=all-ones, out_index=0, out_count=1.
REQ-042 out_ready held low 5 cycles in DONE -> out_valid=1, in_ready=0, outputs stable throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-043 Two beats 9,8, then abort, then 4(last) -> out_data=4, out_count=1, out_index=0; a beat presented during the abort cycle is not accepted.
REQ-044 IDX_WIDTH=2, mode=0, burst 9,9,9,9,2(last) -> out_data=2, out_index=3, out_count=3, out_ovf=1.
REQ-045 rst_n pulsed low in ACCUM -> all outputs 0 at once; a subsequent burst 6(last) -> out_data=6, out_count=1.

Source files
------------

// File: rtl/minmax_reduce_uint.sv
// rtl/minmax_reduce_uint.sv - streaming unsigned min/max reduction with winner index and element count
module minmax_reduce_uint #(
   parameter int WIDTH     = 64,
   parameter int IDX_WIDTH = 16,
   parameter int IMPL_TYPE = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 abort,
   input  logic                 mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [IDX_WIDTH-1:0] out_index,
   output logic [IDX_WIDTH-1:0] out_count,
   output logic                 out_ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [IDX_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [IDX_WIDTH-1:0] CNT_ONE = IDX_WIDTH'(1);

   state_t               state;
   state_t               state_next;
   logic [WIDTH-1:0]     acc;
   logic [IDX_WIDTH-1:0] idx;
   logic [IDX_WIDTH-1:0] count;
   logic                 ovf;
   logic                 mode_q;
   logic                 accept;
   logic [WIDTH-1:0]     cmp_lhs;
   logic [WIDTH-1:0]     cmp_rhs;
   logic                 gt;

   assign in_ready = (state != DONE) && !abort;
   assign accept   = in_valid && in_ready;

   // Min mode asks "acc > in_data", max mode asks "in_data > acc"; strict so ties keep the earlier winner
   assign cmp_lhs = mode_q ? in_data : acc;
   assign cmp_rhs = mode_q ? acc : in_data;

   generate
      if (IMPL_TYPE == 0) begin : g_cmp_direct
         assign gt = cmp_lhs > cmp_rhs;
      end else begin : g_cmp_msb_scan
         // First differing bit from the MSB down decides the unsigned ordering
         always_comb begin
            logic decided;
            gt      = 1'b0;
            decided = 1'b0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
               if (!decided && (cmp_lhs[i] != cmp_rhs[i])) begin
                  gt      = cmp_lhs[i];
                  decided = 1'b1;
               end
            end
         end
      end
   endgenerate

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: abort wins outside DONE, result is held in DONE until consumed
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = in_last ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (abort) begin
               state_next = IDLE;
            end else if (accept && in_last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Accumulator, winner index, saturating count and sticky overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         idx    <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         mode_q <= 1'b0;
      end else if ((state != DONE) && abort) begin
         acc   <= '0;
         idx   <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else if (accept) begin
         if (state == IDLE) begin
            acc    <= in_data;
            idx    <= '0;
            count  <= CNT_ONE;
            ovf    <= 1'b0;
            mode_q <= mode;
         end else begin
            if (gt) begin
               acc <= in_data;
               idx <= count;
            end
            if (count == CNT_MAX) begin
               ovf <= 1'b1;
            end else begin
               count <= count + CNT_ONE;
            end
         end
      end
   end

   assign out_valid = (state == DONE);
   assign out_data  = acc;
   assign out_index = idx;
   assign out_count = count;
   assign out_ovf   = ovf;

endmodule

// File: tb/tb_minmax_reduce_uint.sv
// tb/tb_minmax_reduce_uint.sv - scoreboard bench for minmax_reduce_uint, two parameterisations on shared stimulus
module tb_minmax_reduce_uint;

   typedef struct {
      logic [63:0] d;
      int          i;
      int          c;
      bit          o;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        abort;
   logic        mode;
   logic        in_valid;
   logic        in_last;
   logic        out_ready;
   logic [63:0] in_data;

   logic        in_ready0, out_valid0, out_ovf0;
   logic [7:0]  out_data0;
   logic [3:0]  out_index0, out_count0;

   logic        in_ready1, out_valid1, out_ovf1;
   logic [63:0] out_data1;
   logic [1:0]  out_index1, out_count1;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [63:0] vec[$];

   int checks   = 0;
   int failures = 0;

   minmax_reduce_uint #(.WIDTH(8), .IDX_WIDTH(4), .IMPL_TYPE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .abort(abort), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data[7:0]), .in_last(in_last),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
      .out_index(out_index0), .out_count(out_count0), .out_ovf(out_ovf0)
   );

   minmax_reduce_uint #(.WIDTH(64), .IDX_WIDTH(2), .IMPL_TYPE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .abort(abort), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .out_index(out_index1), .out_count(out_count1), .out_ovf(out_ovf1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic expect2(input logic [63:0] d0, input int i0, input int c0, input bit o0,
                          input logic [63:0] d1, input int i1, input int c1, input bit o1);
      exp_t e;
      e.d = d0; e.i = i0; e.c = c0; e.o = o0;
      q0.push_back(e);
      e.d = d1; e.i = i1; e.c = c1; e.o = o1;
      q1.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [63:0] d, input logic last, input logic m);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      mode     = m;
      @(negedge clk);
      while (!in_ready0 && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("in_ready_wait", {63'd0, in_ready0}, 64'd1);
      chk("in_ready1_match", {63'd0, in_ready1}, 64'd1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Sends vec as one burst; mode flips from beat toggle_at onward; returns at the first DONE negedge
   task automatic burst(input logic m, input int toggle_at);
      for (int i = 0; i < vec.size(); i++) begin
         beat(vec[i], (i == vec.size() - 1), (toggle_at >= 0 && i >= toggle_at) ? ~m : m);
      end
      @(negedge clk);
      chk("latency_out_valid0", {63'd0, out_valid0}, 64'd1);
      chk("latency_out_valid1", {63'd0, out_valid1}, 64'd1);
   endtask

   // Monitor: pop and compare whenever a result handshake is about to happen
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid0 && out_ready) begin
         if (q0.size() == 0) begin
            chk("dut0_unexpected_result", 64'd1, 64'd0);
         end else begin
            e = q0.pop_front();
            chk("dut0_data", {56'd0, out_data0}, e.d);
            chk("dut0_index", {60'd0, out_index0}, 64'(e.i));
            chk("dut0_count", {60'd0, out_count0}, 64'(e.c));
            chk("dut0_ovf", {63'd0, out_ovf0}, {63'd0, e.o});
         end
      end
      if (rst_n && out_valid1 && out_ready) begin
         if (q1.size() == 0) begin
            chk("dut1_unexpected_result", 64'd1, 64'd0);
         end else begin
            e = q1.pop_front();
            chk("dut1_data", out_data1, e.d);
            chk("dut1_index", {62'd0, out_index1}, 64'(e.i));
            chk("dut1_count", {62'd0, out_count1}, 64'(e.c));
            chk("dut1_ovf", {63'd0, out_ovf1}, {63'd0, e.o});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      rst_n     = 1'b0;
      abort     = 1'b0;
      mode      = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      in_data   = '0;
      repeat (2) step();

      // Reset state
      @(negedge clk);
      chk("rst_out_valid0", {63'd0, out_valid0}, 64'd0);
      chk("rst_out_data0", {56'd0, out_data0}, 64'd0);
      chk("rst_out_count0", {60'd0, out_count0}, 64'd0);
      chk("rst_out_ovf1", {63'd0, out_ovf1}, 64'd0);
      rst_n = 1'b1;
      step();
      @(negedge clk);
      chk("post_rst_in_ready0", {63'd0, in_ready0}, 64'd1);
      chk("post_rst_out_valid1", {63'd0, out_valid1}, 64'd0);
      step();

      // Min with a tie at the end; dut1 saturates its 2-bit count
      expect2(64'd3, 1, 4, 1'b0, 64'd3, 1, 3, 1'b1);
      vec = '{64'd5, 64'd3, 64'd9, 64'd3};
      burst(1'b0, -1);
      step();

      // Max, mode flipped from the second beat onward, tie at 200
      expect2(64'd200, 1, 4, 1'b0, 64'd200, 1, 3, 1'b1);
      vec = '{64'd7, 64'd200, 64'd200, 64'd1};
      burst(1'b1, 1);
      step();

      // Single all-ones beat
      expect2(64'hFF, 0, 1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 1'b0);
      vec = '{64'hFFFF_FFFF_FFFF_FFFF};
      burst(1'b0, -1);
      step();

      // Unsigned max across the MSB
      expect2(64'hFF, 1, 2, 1'b0, 64'h8000_0000_0000_0000, 0, 2, 1'b0);
      vec = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};
      burst(1'b1, -1);
      step();

      // Unsigned min across the MSB
      expect2(64'h7F, 1, 2, 1'b0, 64'h80, 0, 2, 1'b0);
      vec = '{64'h0000_0000_0000_0080, 64'hFFFF_FFFF_FFFF_FF7F};
      burst(1'b0, -1);
      step();

      // Saturation on dut1: position clamps at 3, ovf set
      expect2(64'd2, 4, 5, 1'b0, 64'd2, 3, 3, 1'b1);
      vec = '{64'd9, 64'd9, 64'd9, 64'd9, 64'd2};
      burst(1'b0, -1);
      step();

      // Back-pressure in DONE, with an ignored abort in the middle
      out_ready = 1'b0;
      expect2(64'd2, 1, 2, 1'b0, 64'd2, 1, 2, 1'b0);
      vec = '{64'd1, 64'd2};
      burst(1'b1, -1);
      for (int k = 0; k < 5; k++) begin
         step();
         abort = (k == 2);
         @(negedge clk);
         chk("hold_out_valid0", {63'd0, out_valid0}, 64'd1);
         chk("hold_in_ready0", {63'd0, in_ready0}, 64'd0);
         chk("hold_out_data0", {56'd0, out_data0}, 64'd2);
         chk("hold_out_index0", {60'd0, out_index0}, 64'd1);
         chk("hold_out_count1", {62'd0, out_count1}, 64'd2);
         chk("hold_out_data1", out_data1, 64'd2);
      end
      step();
      abort     = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      step();
      @(negedge clk);
      chk("release_out_valid0", {63'd0, out_valid0}, 64'd0);
      chk("release_in_ready0", {63'd0, in_ready0}, 64'd1);
      step();

      // Abort mid-burst; the beat offered during abort must be dropped
      expect2(64'd4, 0, 1, 1'b0, 64'd4, 0, 1, 1'b0);
      beat(64'd9, 1'b0, 1'b0);
      beat(64'd8, 1'b0, 1'b0);
      in_valid = 1'b1;
      in_data  = 64'd1;
      in_last  = 1'b1;
      abort    = 1'b1;
      @(negedge clk);
      chk("abort_in_ready0", {63'd0, in_ready0}, 64'd0);
      step();
      abort    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      vec = '{64'd4};
      burst(1'b0, -1);
      step();

      // Asynchronous reset in ACCUM clears outputs immediately
      beat(64'd6, 1'b0, 1'b0);
      beat(64'd7, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid0", {63'd0, out_valid0}, 64'd0);
      chk("async_rst_out_data0", {56'd0, out_data0}, 64'd0);
      chk("async_rst_out_count0", {60'd0, out_count0}, 64'd0);
      chk("async_rst_out_index0", {60'd0, out_index0}, 64'd0);
      chk("async_rst_out_ovf0", {63'd0, out_ovf0}, 64'd0);
      chk("async_rst_out_data1", out_data1, 64'd0);
      chk("async_rst_out_count1", {62'd0, out_count1}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      expect2(64'd6, 0, 1, 1'b0, 64'd6, 0, 1, 1'b0);
      vec = '{64'd6};
      burst(1'b0, -1);
      step();

      repeat (3) step();
      chk("q0_drained", 64'(q0.size()), 64'd0);
      chk("q1_drained", 64'(q1.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
